// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command encodings, FSM state type and width defaults for the RAM port arbiter
package mem_pkg;

   localparam int AW_DEF = 9;
   localparam int DW_DEF = 16;

   localparam logic [1:0] MREAD  = 2'b11;
   localparam logic [1:0] MWRITE = 2'b10;
   localparam logic [1:0] MNONE  = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } arb_state_t;

   // Only real RAM operations may win arbitration; anything else is ignored.
   function automatic logic cmd_is_valid(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational 2-way round-robin selector
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       owner_o,
   output logic       valid_o
);

   // A lone requester wins; on a tie the port that was not served last wins.
   always_comb begin
      valid_o = |req_i;
      owner_o = 1'b0;
      if (req_i == 2'b11) begin
         owner_o = ~last_i;
      end else begin
         owner_o = req_i[1];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of the single-port RAM between cpu and loader ports
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [1:0]    cmd0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic [1:0]    cmd1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [1:0]    grant,
   output logic          busy,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data
);

   // Wait-state count loaded on entry to S_WAIT; S_WAIT lasts RD_LAT cycles.
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   arb_state_t    state_q;
   logic          owner_q;
   logic          last_q;
   logic [1:0]    cmd_q;
   logic [1:0]    cnt_q;
   logic          ack0_q;
   logic          ack1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;
   logic [1:0]    grant_q;
   logic [1:0]    mem_cmd_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] write_data_q;

   logic [1:0]    req_vld;
   logic          pick_owner;
   logic          pick_valid;
   logic [1:0]    cmd_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;

   // Filter out requests carrying a non-RAM command before arbitration.
   always_comb begin
      req_vld[0] = req0 & cmd_is_valid(cmd0);
      req_vld[1] = req1 & cmd_is_valid(cmd1);
   end

   rr_pick2 u_pick (
      .req_i   (req_vld),
      .last_i  (last_q),
      .owner_o (pick_owner),
      .valid_o (pick_valid)
   );

   // Fields of the winning port, latched only when leaving S_IDLE.
   always_comb begin
      cmd_d   = pick_owner ? cmd1   : cmd0;
      addr_d  = pick_owner ? addr1  : addr0;
      wdata_d = pick_owner ? wdata1 : wdata0;
   end

   // Arbitration FSM; every RAM-facing output and handshake is a register here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         cmd_q        <= MNONE;
         cnt_q        <= 2'd0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         grant_q      <= 2'b00;
         mem_cmd_q    <= MNONE;
         mem_addr_q   <= '0;
         write_data_q <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pick_valid) begin
                  owner_q      <= pick_owner;
                  cmd_q        <= cmd_d;
                  mem_cmd_q    <= cmd_d;
                  mem_addr_q   <= addr_d;
                  write_data_q <= wdata_d;
                  grant_q      <= pick_owner ? 2'b10 : 2'b01;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_q == MWRITE) begin
                  // The write strobe is exactly the one ISSUE cycle.
                  mem_cmd_q <= MNONE;
                  ack0_q    <= ~owner_q;
                  ack1_q    <= owner_q;
                  state_q   <= S_DONE;
               end else begin
                  // Keep MREAD and the address on the RAM until data is captured.
                  cnt_q   <= CNT_INIT;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 2'd0) begin
                  if (owner_q) begin
                     rdata1_q <= read_data;
                  end else begin
                     rdata0_q <= read_data;
                  end
                  mem_cmd_q <= MNONE;
                  ack0_q    <= ~owner_q;
                  ack1_q    <= owner_q;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            S_DONE: begin
               last_q  <= owner_q;
               grant_q <= 2'b00;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs are pure register taps; busy decodes the registered state only.
   always_comb begin
      ack0       = ack0_q;
      ack1       = ack1_q;
      rdata0     = rdata0_q;
      rdata1     = rdata1_q;
      grant      = grant_q;
      busy       = (state_q != S_IDLE);
      mem_cmd    = mem_cmd_q;
      mem_addr   = mem_addr_q;
      write_data = write_data_q;
   end

endmodule
